// File: rtl/vga_frame_monitor_if.sv
// Video bus between a VGA timing/pixel source and the frame monitor.
// The source drives syncs, blanking and colour; the monitor returns recovered coordinates and status.
interface vga_frame_monitor_if;
    logic        hsync;
    logic        vsync;
    logic        blank_b;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [9:0]  x_rx;
    logic [9:0]  y_rx;
    logic        pix_valid;
    logic        frame_done;
    logic [23:0] frame_sum;
    logic        frame_ok;
    logic        line_err;
    logic        locked;

    modport master (
        output hsync, vsync, blank_b, red, green, blue,
        input  x_rx, y_rx, pix_valid, frame_done, frame_sum, frame_ok, line_err, locked
    );

    modport slave (
        input  hsync, vsync, blank_b, red, green, blue,
        output x_rx, y_rx, pix_valid, frame_done, frame_sum, frame_ok, line_err, locked
    );
endinterface

// File: rtl/vga_frame_monitor.sv
// Receive-side VGA monitor: recovers pixel coordinates, checks line/frame timing,
// signs each frame with a rotate-xor signature and tracks lock over consecutive good frames.
module vga_frame_monitor #(
    parameter int HACTIVE = 640,
    parameter int VACTIVE = 480,
    parameter int HTOTAL  = 800,
    parameter int VTOTAL  = 525
) (
    input  logic               vgaclk,
    input  logic               reset,
    vga_frame_monitor_if.slave bus
);

    localparam logic [11:0] C_HACTIVE = 12'(HACTIVE);
    localparam logic [11:0] C_VACTIVE = 12'(VACTIVE);
    localparam logic [11:0] C_HTOTAL  = 12'(HTOTAL);
    localparam logic [11:0] C_VTOTAL  = 12'(VTOTAL);

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        CHECK1,
        LOCKED
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_hs_prev;
    logic        r_vs_prev;
    logic        r_blank_prev;

    logic [11:0] r_hcount_act;
    logic [11:0] r_vcount_act;
    logic [11:0] r_hperiod;
    logic [11:0] r_line_cnt;
    logic        r_hp_valid;
    logic        r_frame_bad;
    logic [23:0] r_sig;

    logic [9:0]  r_x_rx;
    logic [9:0]  r_y_rx;
    logic        r_pix_valid;
    logic        r_frame_done;
    logic [23:0] r_frame_sum;
    logic        r_frame_ok;
    logic        r_line_err;
    logic        r_locked;

    logic        w_hs_fall;
    logic        w_vs_fall;
    logic        w_act_end;
    logic        w_active;
    logic        w_hlen_err;
    logic        w_hper_err;
    logic        w_line_err;
    logic [11:0] w_lines_total;
    logic [11:0] w_act_lines;
    logic        w_frame_good;
    logic        w_frame_done;
    logic [23:0] w_sig_upd;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    assign w_hs_fall = r_hs_prev & ~bus.hsync;
    assign w_vs_fall = r_vs_prev & ~bus.vsync;
    assign w_act_end = r_blank_prev & ~bus.blank_b;
    assign w_active  = (r_state != SEARCH);

    // The first hs_fall after leaving SEARCH has no trusted reference, hence r_hp_valid.
    assign w_hlen_err = w_active & w_act_end & (r_hcount_act != C_HACTIVE);
    assign w_hper_err = w_active & w_hs_fall & r_hp_valid & (r_hperiod != C_HTOTAL);
    assign w_line_err = w_hlen_err | w_hper_err;

    // Events coinciding with vs_fall still belong to the frame being closed.
    assign w_lines_total = w_hs_fall ? sat_inc(r_line_cnt)   : r_line_cnt;
    assign w_act_lines   = w_act_end ? sat_inc(r_vcount_act) : r_vcount_act;
    assign w_frame_good  = (w_lines_total == C_VTOTAL) && (w_act_lines == C_VACTIVE)
                           && !r_frame_bad && !w_line_err;

    assign w_sig_upd = bus.blank_b ? ({r_sig[22:0], r_sig[23]} ^ {bus.red, bus.green, bus.blue})
                                   : r_sig;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_frame_done = 1'b0;
        unique case (r_state)
            SEARCH: begin
                if (w_vs_fall) w_state_next = ACQUIRE;
            end
            ACQUIRE: begin
                w_frame_done = w_vs_fall;
                if (w_vs_fall && w_frame_good) w_state_next = CHECK1;
            end
            CHECK1: begin
                w_frame_done = w_vs_fall;
                if (w_vs_fall) w_state_next = w_frame_good ? LOCKED : ACQUIRE;
            end
            LOCKED: begin
                w_frame_done = w_vs_fall;
                if (w_line_err || (w_vs_fall && !w_frame_good)) w_state_next = ACQUIRE;
            end
            default: w_state_next = SEARCH;
        endcase
    end

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            r_state <= SEARCH;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            // NOTE: edge history resets to idle line levels so releasing reset cannot fake an edge.
            r_hs_prev    <= 1'b1;
            r_vs_prev    <= 1'b1;
            r_blank_prev <= 1'b0;
            r_hcount_act <= '0;
            r_vcount_act <= '0;
            r_hperiod    <= '0;
            r_line_cnt   <= '0;
            r_hp_valid   <= 1'b0;
            r_frame_bad  <= 1'b0;
            r_sig        <= '0;
            r_x_rx       <= '0;
            r_y_rx       <= '0;
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_sum  <= '0;
            r_frame_ok   <= 1'b0;
            r_line_err   <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_hs_prev    <= bus.hsync;
            r_vs_prev    <= bus.vsync;
            r_blank_prev <= bus.blank_b;

            r_pix_valid <= bus.blank_b & w_active;
            if (bus.blank_b) begin
                r_hcount_act <= sat_inc(r_hcount_act);
                if (w_active) begin
                    r_x_rx <= r_hcount_act[9:0];
                    r_y_rx <= r_vcount_act[9:0];
                end
            end else if (w_act_end) begin
                r_hcount_act <= '0;
            end

            if (w_vs_fall)      r_vcount_act <= '0;
            else if (w_act_end) r_vcount_act <= sat_inc(r_vcount_act);

            r_hperiod <= w_hs_fall ? 12'd1 : sat_inc(r_hperiod);

            if (w_vs_fall)      r_line_cnt <= '0;
            else if (w_hs_fall) r_line_cnt <= sat_inc(r_line_cnt);

            if (!w_active)      r_hp_valid <= 1'b0;
            else if (w_hs_fall) r_hp_valid <= 1'b1;

            if (w_vs_fall || !w_active) r_frame_bad <= 1'b0;
            else if (w_line_err)        r_frame_bad <= 1'b1;

            r_sig <= w_vs_fall ? 24'h0 : w_sig_upd;

            r_frame_done <= w_frame_done;
            if (w_frame_done) begin
                r_frame_sum <= w_sig_upd;
                r_frame_ok  <= w_frame_good;
            end

            r_line_err <= w_line_err;
            r_locked   <= (w_state_next == LOCKED);
        end
    end

    assign bus.x_rx       = r_x_rx;
    assign bus.y_rx       = r_y_rx;
    assign bus.pix_valid  = r_pix_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_sum  = r_frame_sum;
    assign bus.frame_ok   = r_frame_ok;
    assign bus.line_err   = r_line_err;
    assign bus.locked     = r_locked;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a scaled-down raster (8x3 active, 16x8 total).
// Line: hsync low c0-1, active c4-11; frame: vsync low lines 0-1, active lines 2-4.
module tb_vga_frame_monitor;

    localparam int HA = 8;
    localparam int VA = 3;
    localparam int HT = 16;
    localparam int VT = 8;

    logic vgaclk = 1'b0;
    logic reset  = 1'b1;

    vga_frame_monitor_if bus();

    vga_frame_monitor #(
        .HACTIVE(HA),
        .VACTIVE(VA),
        .HTOTAL (HT),
        .VTOTAL (VT)
    ) dut (
        .vgaclk(vgaclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 vgaclk = ~vgaclk;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_done = 0;
    int          n_lerr = 0;
    int          done_snap;
    logic        q_ok[$];
    logic [23:0] q_sum[$];
    logic        pre_pv;
    logic        fp_pre, fp_pv;
    logic [9:0]  fp_x, fp_y;
    logic [9:0]  last_x, last_y;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pixel clock: drive, sample registered outputs just before and just after the edge.
    task automatic tick(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
        bus.hsync   = hs;
        bus.vsync   = vs;
        bus.blank_b = bl;
        {bus.red, bus.green, bus.blue} = rgb;
        #1;
        pre_pv = bus.pix_valid;
        @(posedge vgaclk);
        #1;
        if (bus.frame_done === 1'b1) begin
            n_done++;
            q_ok.push_back(bus.frame_ok);
            q_sum.push_back(bus.frame_sum);
        end
        if (bus.line_err === 1'b1) n_lerr++;
        if (bus.pix_valid === 1'b1) begin
            last_x = bus.x_rx;
            last_y = bus.y_rx;
        end
    endtask

    task automatic frame(input int nlines, input int short_ln, input logic [23:0] p00);
        for (int ln = 0; ln < nlines; ln++) begin
            for (int c = 0; c < HT; c++) begin
                int   len;
                logic act;
                len = (ln == short_ln) ? HA - 1 : HA;
                act = (ln >= 2) && (ln < 2 + VA) && (c >= 4) && (c < 4 + len);
                tick(c >= 2, ln >= 2, act, (ln == 2 && c == 4) ? p00 : 24'h0);
                if (ln == 2 && c == 4) begin
                    fp_pre = pre_pv;
                    fp_pv  = bus.pix_valid;
                    fp_x   = bus.x_rx;
                    fp_y   = bus.y_rx;
                end
            end
        end
    endtask

    task automatic hold_line(input int low, input int high);
        for (int i = 0; i < low; i++)  tick(1'b0, 1'b1, 1'b0, 24'h0);
        for (int i = 0; i < high; i++) tick(1'b1, 1'b1, 1'b0, 24'h0);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_pix_valid"},  bus.pix_valid,  0);
        check({pfx, "_x_rx"},       bus.x_rx,       0);
        check({pfx, "_y_rx"},       bus.y_rx,       0);
        check({pfx, "_frame_done"}, bus.frame_done, 0);
        check({pfx, "_frame_sum"},  bus.frame_sum,  0);
        check({pfx, "_frame_ok"},   bus.frame_ok,   0);
        check({pfx, "_line_err"},   bus.line_err,   0);
        check({pfx, "_locked"},     bus.locked,     0);
    endtask

    initial begin
        // Power-on reset with idle lines.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 24'h0);
        check_all_zero("por");
        reset = 1'b0;

        // Part of an active line while searching, then reset mid-line.
        for (int c = 0; c < 10; c++) tick(c >= 2, 1'b1, c >= 4, 24'hFFFFFF);
        check("search_pix_idle", bus.pix_valid, 0);
        #2;
        reset       = 1'b1;
        bus.blank_b = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 24'h0);
        reset = 1'b0;
        n_done = 0;
        n_lerr = 0;
        q_ok.delete();
        q_sum.delete();

        // Three nominal all-black frames: lock on the third vs_fall.
        frame(VT, -1, 24'h0);
        check("no_done_first_vs", n_done, 0);
        frame(VT, -1, 24'h0);
        check("locked_after_2", bus.locked, 0);
        frame(VT, -1, 24'h0);
        check("locked_after_3", bus.locked, 1);
        check("done_count_3", n_done, 2);
        check("done1_ok", q_ok[0], 1);
        check("done2_ok", q_ok[1], 1);
        check("sum_black", q_sum[1], 24'h0);
        check("lerr_nominal", n_lerr, 0);
        check("last_x", last_x, HA - 1);
        check("last_y", last_y, VA - 1);
        check("x_hold_blank", bus.x_rx, HA - 1);

        // Single pixel at (0,0) and pixel-path latency.
        frame(VT, -1, 24'h000001);
        check("first_pix_pre", fp_pre, 0);
        check("first_pix_valid", fp_pv, 1);
        check("first_pix_x", fp_x, 0);
        check("first_pix_y", fp_y, 0);
        frame(VT, -1, 24'hABCDEF);
        check("sum_single_1", q_sum[3], 24'h800000);
        check("locked_pre_short", bus.locked, 1);

        // Short line while locked.
        frame(VT, 3, 24'h0);
        check("sum_abcdef", q_sum[4], 24'hD5E6F7);
        check("lerr_short", n_lerr, 1);
        check("unlock_short", bus.locked, 0);
        frame(VT, -1, 24'h0);
        check("short_frame_ok", q_ok[5], 0);
        frame(VT, -1, 24'h0);
        check("relock_pending", bus.locked, 0);
        frame(VT, -1, 24'h0);
        check("relock_ok7", q_ok[6], 1);
        check("relock_ok8", q_ok[7], 1);
        check("relocked", bus.locked, 1);

        // Wrong line counts per frame.
        frame(VT - 1, -1, 24'h0);
        check("locked_before_524", bus.locked, 1);
        frame(VT + 1, -1, 24'h000001);
        check("lines_short_ok", q_ok[9], 0);
        check("unlock_lines", bus.locked, 0);
        frame(VT, -1, 24'h0);
        check("lines_long_ok", q_ok[10], 0);
        check("lines_long_sum", q_sum[10], 24'h800000);
        check("done_count_all", n_done, 11);
        check("locked_acquire", bus.locked, 0);

        // Over-long hsync periods: 4112 would alias to 16 if the counter wrapped.
        hold_line(4100, 12);
        check("lerr_before_long", n_lerr, 1);
        hold_line(5000, 10);
        check("lerr_period_4112", n_lerr, 2);
        tick(1'b0, 1'b1, 1'b0, 24'h0);
        check("lerr_period_5010", n_lerr, 3);
        hold_line(20, 0);
        check("sum_before_arst", bus.frame_sum, 24'h800000);

        // Asynchronous reset between clock edges while hsync is held low.
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("arst");
        tick(1'b0, 1'b1, 1'b0, 24'h0);
        reset = 1'b0;
        done_snap = n_done;
        frame(VT, -1, 24'h0);
        check("arst_no_done", n_done, done_snap);
        check("arst_unlocked", bus.locked, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
- Receive-side counterpart of the VGA timing/pixel generator. Sits on the vgaclk domain and consumes hsync, vsync, blank_b and 24-bit RGB as driven to the DAC.
- Recovers pixel coordinates and measures line and frame timing against expected parameters.
- Computes a per-frame pixel signature so the board-drawing logic can be checked in simulation and by on-chip self-test.
- Reports lock status and timing errors.

Parameters:
- HACTIVE, 640, active pixels per line
- VACTIVE, 480, active lines per frame
- HTOTAL, 800, vgaclk cycles per line (hsync falling edge to next hsync falling edge)
- VTOTAL, 525, lines per frame (hsync falling edges between vsync falling edges)

Ports:
- vgaclk  in  1  pixel clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- blank_b  in  1  1 = active video pixel
- red, green, blue  in  8 each  pixel colour, sampled when blank_b=1
- x_rx  out  10  recovered column of the pixel flagged by pix_valid
- y_rx  out  10  recovered row of the pixel flagged by pix_valid
- pix_valid  out  1  registered blank_b
- frame_done  out  1  one-cycle pulse at each frame boundary; frame results valid in that cycle
- frame_sum  out  24  signature of the last completed frame
- frame_ok  out  1  last completed frame met every timing check
- line_err  out  1  one-cycle pulse on a bad line length or period
- locked  out  1  two consecutive good frames seen, no error since

Behaviour:
- Reset:
  - All outputs 0; all counters and the signature 0.
  - Edge-detect registers load 1 for hsync/vsync and 0 for blank_b.
  - State goes to SEARCH.
  - Reset asserted mid-frame discards the partial frame; no frame_done is produced for it.
- Edges: prev-value registers feed the edge detectors.
  - vs_fall = vsync 1→0.
  - hs_fall = hsync 1→0.
  - act_end = blank_b 1→0.
- Pixel path, latency 1 cycle:
  - pix_valid <= blank_b.
  - x_rx <= hcount_act, and hcount_act then increments. hcount_act clears on act_end.
  - y_rx <= vcount_act. vcount_act increments on act_end and clears on vs_fall.
  - x_rx and y_rx hold their value when pix_valid=0.
- Signature: on each blank_b=1 cycle, sig <= {sig[22:0],sig[23]} ^ {red,green,blue}. sig clears on vs_fall after being copied to frame_sum.
- Line checks:
  - On act_end, if the active length != HACTIVE → line_err pulse, and the frame is marked bad.
  - On hs_fall, if the cycle count since the previous hs_fall != HTOTAL → line_err pulse, and the frame is marked bad. The first hs_fall after leaving SEARCH is not checked.
- Frame checks on vs_fall: the frame is good iff line count == VTOTAL, active line count == VACTIVE, and no line_err occurred during the frame.
- Counter widths: 12 bits, saturating at 4095 (no wrap). A saturated count therefore fails its check.
- States:
  - SEARCH: outputs idle, no checks. On vs_fall → ACQUIRE; counters and signature are cleared; no frame_done.
  - ACQUIRE: on vs_fall, frame_done=1 and frame_sum/frame_ok are updated. Good frame → CHECK1; bad frame → stay in ACQUIRE.
  - CHECK1: on vs_fall, frame_done=1. Good → LOCKED (locked=1 from the next cycle); bad → ACQUIRE.
  - LOCKED: on vs_fall, frame_done=1. Good → stay; bad → ACQUIRE with locked=0. Any line_err in LOCKED drops locked the following cycle and moves to ACQUIRE; the current frame then completes as bad.
- Simultaneous events:
  - vs_fall and hs_fall in the same cycle: count the line into the closing frame, then clear.
  - act_end in the same cycle as vs_fall: that line counts toward the closing frame.
- frame_sum and frame_ok hold their value between frame_done pulses.

Test Plan:
- Reset asserted mid-line, then released; then 3 nominal 640x480 frames (800x525) → locked=1 after the 3rd vs_fall. Exactly 2 frame_done pulses with frame_ok=1; none for the first vs_fall.
- Frame all black except pixel (0,0) = 0x000001 → on the next frame_done, frame_sum = 0x800000. pix_valid with x_rx=0,y_rx=0 occurs exactly 1 cycle after blank_b rises.
- All-black frame → frame_sum = 0x000000. The last pixel shows x_rx=639, y_rx=479.
- In the locked state, one line shortened to 639 active pixels → a single line_err pulse and locked=0 the next cycle. That frame gives frame_ok=0; two more good frames relock.
- Frame of 524 lines → frame_ok=0 at its vs_fall and state goes back to ACQUIRE. Then 526 lines → frame_ok=0 again.
- hsync held low for 5000 cycles → the period counter saturates at 4095 and the line is flagged. Asserting reset during this → all outputs 0 and state SEARCH immediately (asynchronous).
